// File: rtl/divider_seq.sv
// Iterative restoring divider, one quotient bit per cycle, optional two's-complement operands.
// Latency: done pulses WIDTH_A+1 cycles after start is accepted; outputs are registered.
// Backpressure: en=0 freezes everything, and start is accepted only while idle.
module divider_seq #(
    parameter int WIDTH_A = 16,
    parameter int WIDTH_B = 16,
    parameter int SIGNED  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               start,
    input  logic [WIDTH_A-1:0] A,
    input  logic [WIDTH_B-1:0] B,
    output logic               busy,
    output logic               done,
    output logic [WIDTH_A-1:0] Q,
    output logic [WIDTH_B-1:0] R,
    output logic               div_zero
);

    localparam int CW = (WIDTH_A > 1) ? $clog2(WIDTH_A) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH_A - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [WIDTH_A-1:0] dvd;
    logic [WIDTH_A-1:0] a_raw;
    logic [WIDTH_B-1:0] rem;
    logic [WIDTH_B-1:0] b_mag;
    logic               q_neg, r_neg, b_zero;

    logic               a_neg_in, b_neg_in;
    logic [WIDTH_A-1:0] a_mag_in;
    logic [WIDTH_B-1:0] b_mag_in;
    logic [WIDTH_B:0]   partial;
    logic [WIDTH_B-1:0] diff;
    logic               fits;
    logic [WIDTH_A-1:0] q_fix;
    logic [WIDTH_B-1:0] r_fix;
    logic [WIDTH_B-1:0] a_raw_fit;

    assign a_neg_in = (SIGNED != 0) && A[WIDTH_A-1];
    assign b_neg_in = (SIGNED != 0) && B[WIDTH_B-1];
    assign a_mag_in = a_neg_in ? -A : A;
    assign b_mag_in = b_neg_in ? -B : B;

    // Partial remainder never exceeds 2*|B|-1, so WIDTH_B+1 bits suffice and diff fits in WIDTH_B.
    assign partial = {rem, dvd[WIDTH_A-1]};
    assign fits    = partial >= {1'b0, b_mag};
    assign diff    = partial[WIDTH_B-1:0] - b_mag;

    assign q_fix = q_neg ? -dvd : dvd;
    assign r_fix = r_neg ? -rem : rem;

    generate
        if (WIDTH_B > WIDTH_A) begin : g_ext
            assign a_raw_fit = {{(WIDTH_B-WIDTH_A){(SIGNED != 0) && a_raw[WIDTH_A-1]}}, a_raw};
        end else begin : g_trunc
            assign a_raw_fit = a_raw[WIDTH_B-1:0];
        end
    endgenerate

    assign busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        if (en) begin
            case (state)
                IDLE:    if (start) state_nxt = CALC;
                CALC:    if (cnt == LAST) state_nxt = FIX;
                FIX:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            dvd      <= '0;
            a_raw    <= '0;
            rem      <= '0;
            b_mag    <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            b_zero   <= 1'b0;
            done     <= 1'b0;
            Q        <= '0;
            R        <= '0;
            div_zero <= 1'b0;
        end else if (en) begin
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt    <= '0;
                        dvd    <= a_mag_in;
                        a_raw  <= A;
                        rem    <= '0;
                        b_mag  <= b_mag_in;
                        q_neg  <= a_neg_in ^ b_neg_in;
                        r_neg  <= a_neg_in;
                        b_zero <= (B == '0);
                    end
                end
                CALC: begin
                    // dvd shifts out dividend bits at the top and collects quotient bits at the bottom.
                    dvd <= {dvd[WIDTH_A-2:0], fits};
                    rem <= fits ? diff : partial[WIDTH_B-1:0];
                    cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
                end
                FIX: begin
                    Q        <= b_zero ? '1 : q_fix;
                    R        <= b_zero ? a_raw_fit : r_fix;
                    div_zero <= b_zero;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_seq.sv
// Directed bench for divider_seq: unsigned and signed instances driven in lock-step from shared inputs.
module tb_divider_seq;

    logic        clk = 1'b0;
    logic        rst, en, start;
    logic [15:0] A, B;
    logic        busy_u, done_u, dz_u, busy_s, done_s, dz_s;
    logic [15:0] q_u, r_u, q_s, r_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    divider_seq #(.WIDTH_A(16), .WIDTH_B(16), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .en(en), .start(start), .A(A), .B(B),
        .busy(busy_u), .done(done_u), .Q(q_u), .R(r_u), .div_zero(dz_u)
    );

    divider_seq #(.WIDTH_A(16), .WIDTH_B(16), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .en(en), .start(start), .A(A), .B(B),
        .busy(busy_s), .done(done_s), .Q(q_s), .R(r_s), .div_zero(dz_s)
    );

    typedef struct {
        bit          sgn;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Caller sits at a negedge; start is presented now and accepted at the next posedge.
    task automatic run_div(input bit sgn, input logic [15:0] a, input logic [15:0] b,
                           input int stall_at, input int stall_len, input int mid_at,
                           output int lat, output int bcnt);
        A = a;
        B = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        bcnt = 0;
        while (!(sgn ? done_s : done_u) && lat < 60) begin
            if (sgn ? busy_s : busy_u) bcnt++;
            if (lat == stall_at) en = 1'b0;
            if (lat == stall_at + stall_len) en = 1'b1;
            if (lat == mid_at) begin
                start = 1'b1;
                A = 16'd9;
                B = 16'd3;
            end
            if (lat == mid_at + 1) start = 1'b0;
            @(negedge clk);
            lat++;
        end
        en = 1'b1;
        start = 1'b0;
        chk("busy_low_at_done", {31'd0, sgn ? busy_s : busy_u}, 32'd0);
    endtask

    task automatic chk_result(input string tag, input bit sgn, input logic [15:0] q,
                              input logic [15:0] r, input logic dz);
        chk({tag, "_Q"},  {16'd0, sgn ? q_s : q_u}, {16'd0, q});
        chk({tag, "_R"},  {16'd0, sgn ? r_s : r_u}, {16'd0, r});
        chk({tag, "_dz"}, {31'd0, sgn ? dz_s : dz_u}, {31'd0, dz});
    endtask

    int lat, bcnt;

    initial begin
        vecs[0]  = '{0, 16'd1000,  16'd7,     16'd142,   16'd6,     1'b0};
        vecs[1]  = '{0, 16'h1234,  16'h0000,  16'hFFFF,  16'h1234,  1'b1};
        vecs[2]  = '{0, 16'hFFFF,  16'd1,     16'hFFFF,  16'd0,     1'b0};
        vecs[3]  = '{0, 16'd5,     16'd10,    16'd0,     16'd5,     1'b0};
        vecs[4]  = '{0, 16'hFFFF,  16'hFFFF,  16'd1,     16'd0,     1'b0};
        vecs[5]  = '{0, 16'd40000, 16'd300,   16'd133,   16'd100,   1'b0};
        vecs[6]  = '{1, 16'hFC18,  16'd7,     16'hFF72,  16'hFFFA,  1'b0};
        vecs[7]  = '{1, 16'd1000,  16'hFFF9,  16'hFF72,  16'd6,     1'b0};
        vecs[8]  = '{1, 16'h8000,  16'hFFFF,  16'h8000,  16'd0,     1'b0};
        vecs[9]  = '{1, 16'd5,     16'd10,    16'd0,     16'd5,     1'b0};
        vecs[10] = '{1, 16'hFC18,  16'hFFF9,  16'h008E,  16'hFFFA,  1'b0};
        vecs[11] = '{1, 16'h8000,  16'h0000,  16'hFFFF,  16'h8000,  1'b1};
        vecs[12] = '{1, 16'hFFF9,  16'd2,     16'hFFFD,  16'hFFFF,  1'b0};

        rst = 1'b1;
        en = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy_u | busy_s}, 32'd0);
        chk("rst_done", {31'd0, done_u | done_s}, 32'd0);
        chk("rst_QR",   {q_u | q_s, r_u | r_s}, 32'd0);
        chk("rst_dz",   {31'd0, dz_u | dz_s}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Consecutive vectors start in the previous done cycle, so this also covers back-to-back.
        for (int i = 0; i < 13; i++) begin
            run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, -10, 0, -10, lat, bcnt);
            chk($sformatf("v%0d_latency", i), lat, 32'd17);
            chk($sformatf("v%0d_busy_cycles", i), bcnt, 32'd17);
            chk_result($sformatf("v%0d", i), vecs[i].sgn, vecs[i].q, vecs[i].r, vecs[i].dz);
        end

        @(negedge clk);
        chk("idle_done_low", {31'd0, done_u}, 32'd0);

        run_div(0, 16'd1000, 16'd7, -10, 0, 5, lat, bcnt);
        chk("midstart_latency", lat, 32'd17);
        chk_result("midstart", 0, 16'd142, 16'd6, 1'b0);

        run_div(0, 16'd1000, 16'd7, 4, 3, -10, lat, bcnt);
        chk("stall_latency", lat, 32'd20);
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("stall_done_stretch", {31'd0, done_u}, 32'd1);
        chk_result("stall", 0, 16'd142, 16'd6, 1'b0);
        en = 1'b1;
        @(negedge clk);
        chk("stall_done_clear", {31'd0, done_u}, 32'd0);

        A = 16'd1000;
        B = 16'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy_u}, 32'd0);
        chk("midrst_done", {31'd0, done_u}, 32'd0);
        chk("midrst_QR",   {q_u, r_u}, 32'd0);
        chk("midrst_dz",   {31'd0, dz_u}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_div(0, 16'd1000, 16'd7, -10, 0, -10, lat, bcnt);
        chk("postrst_latency", lat, 32'd17);
        chk_result("postrst", 0, 16'd142, 16'd6, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/divider_seq.md
# divider_seq

Iterative restoring divider that is the inverse datapath of the array multiplier in the MAC/PE arithmetic library. It computes one quotient bit per cycle and supports optional signed operation, divide-by-zero flagging and a global stall enable. The block serves normalization and scaling stages downstream of the systolic array, where throughput demands are low and area matters more than latency.

## Interface
- WIDTH_A, 16, dividend width; quotient width.
- WIDTH_B, 16, divisor width; remainder width.
- SIGNED, 0, 1 = two's-complement operands and results; 0 = unsigned.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  stall control. 0 freezes all state and outputs; `start` is ignored.
- start  input  1  request. Sampled on a rising edge with `en`=1 and `busy`=0.
- A  input  WIDTH_A  dividend, captured on `start` acceptance.
- B  input  WIDTH_B  divisor, captured on `start` acceptance.
- busy  output  1  high while a division is in flight.
- done  output  1  one-cycle pulse; `Q`, `R` and `div_zero` are valid from this cycle.
- Q  output  WIDTH_A  quotient.
- R  output  WIDTH_B  remainder.
- div_zero  output  1  the captured divisor was 0.

## Operation
- States: IDLE, CALC, FIX.
  - IDLE -> CALC on an accepted `start`.
  - CALC -> FIX after exactly WIDTH_A iterations. A counter runs from 0 to WIDTH_A-1.
  - FIX -> IDLE after 1 cycle. The FIX cycle writes the output registers and pulses `done`.
- Capture:
  - If SIGNED=1, operands are converted to magnitude and the signs are stored. Quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).
  - If SIGNED=0, operands are used as-is.
- CALC iteration:
  - Partial remainder (WIDTH_B+1 bits) = {rem, next dividend MSB}.
  - Subtract |B|.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
- FIX:
  - Negate Q and/or R per the stored signs. Results truncate toward zero.
  - Assert `done` for 1 cycle and latch Q, R and div_zero.
- Divide by zero (B==0):
  - Latency is unchanged.
  - Q = all ones.
  - R = A[WIDTH_B-1:0] (raw, sign-extended if WIDTH_B > WIDTH_A).
  - div_zero = 1.
- Signed overflow (A = most-negative, B = -1): Q = most-negative value (wraps), R = 0, div_zero = 0.
- Output holding: Q, R and div_zero hold their last values until the next FIX. `done` is 0 except in the FIX->IDLE cycle.
- `start` while `busy`=1 is ignored and has no side effects.
- Reset mid-operation: the FSM returns to IDLE immediately and the in-flight result is discarded.

## Timing
- Reset values: busy=0, done=0, Q=0, R=0, div_zero=0, state=IDLE, counter=0.
- Latency: if `start` is accepted at edge k with no stalls, then:
  - `busy`=1 after edge k.
  - `done`=1 after edge k+WIDTH_A+1, lasting one cycle.
  - `busy` falls at that same edge.
- Every cycle with `en`=0 delays `done` by one cycle. A `done` pulse in progress stretches while `en`=0.
- Back-to-back: `start` may be asserted in the `done` cycle (busy=0) and is accepted at the next edge. Throughput is one division per WIDTH_A+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Unsigned, defaults: A=1000, B=7 -> after 17 cycles done=1, Q=142, R=6, div_zero=0; busy is high for exactly 17 cycles.
- SIGNED=1: A=-1000, B=7 -> Q=-142 (0xFF72), R=-6 (0xFFFA). A=1000, B=-7 -> Q=-142, R=6.
- Divide by zero: A=0x1234, B=0 -> Q=0xFFFF, R=0x1234, div_zero=1, same 17-cycle latency.
- SIGNED=1 overflow: A=0x8000, B=0xFFFF -> Q=0x8000, R=0. Then A=5, B=10 -> Q=0, R=5.
- Handshake and stall:
  - `start` pulsed mid-operation -> ignored, and the result matches the first operands.
  - `en`=0 held for 3 cycles during CALC -> done arrives at cycle 20.
  - Back-to-back start issued in the done cycle -> second done arrives 17 cycles later.
- Reset: assert `rst` at CALC iteration 5 -> all outputs are 0 immediately. A new start after reset is released yields a correct result with nominal latency.
